// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I subset encoder: mnemonic codes,
// major opcodes, funct3 values and per-format bit-packing helpers.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_XOR  = 4'd1,
    MN_AND  = 4'd2,
    MN_ADDI = 4'd3,
    MN_ANDI = 4'd4,
    MN_SLLI = 4'd5,
    MN_SRLI = 4'd6,
    MN_LBU  = 4'd7,
    MN_SB   = 4'd8,
    MN_BNE  = 4'd9,
    MN_LUI  = 4'd10,
    MN_JAL  = 4'd11,
    MN_JALR = 4'd12
  } mnemonic_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;

  // R-type: funct7 | rs2 | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // I-type: imm[11:0] | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // S-type: the immediate is split around rs2/rs1/funct3
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  // B-type: offset bit 0 is implicit, bits scrambled as the ISA defines
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  // U-type: upper 20 immediate bits placed directly
  function automatic logic [31:0] enc_u(input logic [31:12] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // J-type: offset bit 0 is implicit, bits scrambled as the ISA defines
  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns a mnemonic plus operands into a
// 32-bit RV32I word and flags mnemonic codes outside the subset.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Select the instruction format and fixed fields for each mnemonic
  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (op)
      MN_ADD:  word = enc_r(F7_ZERO, rs2, rs1, F3_ADD, rd, OP_R);
      MN_XOR:  word = enc_r(F7_ZERO, rs2, rs1, F3_XOR, rd, OP_R);
      MN_AND:  word = enc_r(F7_ZERO, rs2, rs1, F3_AND, rd, OP_R);
      MN_ADDI: word = enc_i(imm[11:0], rs1, F3_ADD, rd, OP_I);
      MN_ANDI: word = enc_i(imm[11:0], rs1, F3_AND, rd, OP_I);
      MN_SLLI: word = enc_r(F7_ZERO, imm[4:0], rs1, F3_SLL, rd, OP_I);
      MN_SRLI: word = enc_r(F7_ZERO, imm[4:0], rs1, F3_SRL, rd, OP_I);
      MN_LBU:  word = enc_i(imm[11:0], rs1, F3_LBU, rd, OP_LOAD);
      MN_SB:   word = enc_s(imm[11:0], rs2, rs1, F3_SB, OP_STORE);
      MN_BNE:  word = enc_b(imm[12:1], rs2, rs1, F3_BNE, OP_BRANCH);
      MN_LUI:  word = enc_u(imm[31:12], rd, OP_LUI);
      MN_JAL:  word = enc_j(imm[20:1], rd, OP_JAL);
      MN_JALR: word = enc_i(imm[11:0], rs1, F3_JALR, rd, OP_JALR);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts encode requests over a
// valid/ready handshake and queues {word, byte address} pairs in a
// 2-entry FIFO for the instruction-memory write port.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            op_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [15:0]           count_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrStep  = ADDR_WIDTH'(4);

  logic [31:0]           fifo_instr [2];
  logic [ADDR_WIDTH-1:0] fifo_addr  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occupancy;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [15:0]           count;
  logic                  err;

  logic [31:0]           packed_word;
  logic                  packed_legal;
  logic                  accept;
  logic                  push;
  logic                  pop;

  instr_pack u_pack (
    .op    (op_i),
    .rd    (rd_i),
    .rs1   (rs1_i),
    .rs2   (rs2_i),
    .imm   (imm_i),
    .word  (packed_word),
    .legal (packed_legal)
  );

  // ready depends only on stored occupancy, never on the consumer's ready
  assign ready_o = (occupancy != 2'd2);
  assign valid_o = (occupancy != 2'd0);
  assign accept  = valid_i && ready_o;
  assign push    = accept && packed_legal;
  assign pop     = valid_o && ready_i;

  assign instr_o = fifo_instr[rd_ptr];
  assign addr_o  = fifo_addr[rd_ptr];
  assign count_o = count;
  assign err_o   = err;

  // FIFO storage and pointers; storage is cleared so outputs read 0 after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      fifo_addr[0]  <= '0;
      fifo_addr[1]  <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= packed_word;
        fifo_addr[wr_ptr]  <= addr_cnt;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Address counter, saturating word count and sticky illegal-op flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_cnt <= BaseAddr;
      count    <= 16'h0;
      err      <= 1'b0;
    end else begin
      if (push) begin
        addr_cnt <= addr_cnt + AddrStep;
        if (count != 16'hFFFF) begin
          count <= count + 16'd1;
        end
      end
      if (accept && !packed_legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed and random encode
// requests feed a scoreboard queue; a monitor compares each presented word.
module tb_instr_encoder;

  localparam int AW   = 12;
  localparam int BASE = 'h10;

  logic          clk;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    op_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [31:0]   imm_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   instr_o;
  logic [AW-1:0] addr_o;
  logic [15:0]   count_o;
  logic          err_o;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_vectors;
  int   n_miscompares;
  int   model_addr;
  int   model_count;
  bit   model_err;
  int   ready_mode;
  bit   mon_en;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .rd_i    (rd_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .imm_i   (imm_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .instr_o (instr_o),
    .addr_o  (addr_o),
    .count_o (count_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder written from the ISA field layout
  localparam int FR = 0, FI = 1, FH = 2, FS = 3, FB = 4, FU = 5, FJ = 6;

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input logic [31:0] imm,
                                           output bit legal);
    int opc [13] = '{'h33, 'h33, 'h33, 'h13, 'h13, 'h13, 'h13, 'h03, 'h23, 'h63, 'h37, 'h6F, 'h67};
    int f3  [13] = '{0, 4, 7, 0, 7, 1, 5, 4, 0, 1, 0, 0, 0};
    int fmt [13] = '{FR, FR, FR, FI, FI, FH, FH, FI, FS, FB, FU, FJ, FI};
    logic [31:0] w;
    logic [31:0] i;
    i = imm;
    legal = (op < 13);
    if (!legal) return 32'h0;
    w = 32'(opc[op]) | 32'(f3[op] << 12);
    case (fmt[op])
      FR: w = w | 32'(rd << 7) | 32'(rs1 << 15) | 32'(rs2 << 20);
      FI: w = w | 32'(rd << 7) | 32'(rs1 << 15) | ((i & 32'hFFF) << 20);
      FH: w = w | 32'(rd << 7) | 32'(rs1 << 15) | ((i & 32'h1F) << 20);
      FS: w = w | ((i & 32'h1F) << 7) | 32'(rs1 << 15) | 32'(rs2 << 20)
                | (((i >> 5) & 32'h7F) << 25);
      FB: w = w | (((i >> 11) & 32'h1) << 7) | (((i >> 1) & 32'hF) << 8)
                | 32'(rs1 << 15) | 32'(rs2 << 20) | (((i >> 5) & 32'h3F) << 25)
                | (((i >> 12) & 32'h1) << 31);
      FU: w = w | 32'(rd << 7) | (i & 32'hFFFFF000);
      default: w = w | 32'(rd << 7) | (((i >> 12) & 32'hFF) << 12) | (((i >> 11) & 32'h1) << 20)
                     | (((i >> 1) & 32'h3FF) << 21) | (((i >> 20) & 32'h1) << 31);
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request and update the model on the edge where it is accepted
  task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2,
                               input logic [31:0] imm, input bit has_exp,
                               input logic [31:0] exp_word, input int max_wait);
    bit          acc;
    bit          legal;
    logic [31:0] w;
    exp_t        e;
    int          waited;
    valid_i = 1'b1;
    op_i    = 4'(op);
    rd_i    = 5'(rd);
    rs1_i   = 5'(rs1);
    rs2_i   = 5'(rs2);
    imm_i   = imm;
    waited  = 0;
    forever begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      if (acc) begin
        w = ref_word(op, rd, rs1, rs2, imm, legal);
        if (legal) begin
          e.instr = has_exp ? exp_word : w;
          e.addr  = model_addr[AW-1:0];
          sb.push_back(e);
          model_addr = (model_addr + 4) % (1 << AW);
          if (model_count < 65535) model_count++;
        end else begin
          model_err = 1'b1;
        end
        break;
      end
      waited++;
      if (waited > max_wait) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, expected accept", waited);
        break;
      end
    end
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input int bound);
    ready_mode = 0;
    for (int k = 0; k < bound && sb.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic doReset();
    rst_i   = 1'b1;
    valid_i = 1'b1;
    op_i    = 4'd3;
    rd_i    = 5'd1;
    rs1_i   = 5'd0;
    rs2_i   = 5'd0;
    imm_i   = 32'd7;
    @(posedge clk);
    sb.delete();
    model_addr  = BASE;
    model_count = 0;
    model_err   = 1'b0;
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  // Consumer ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = 1'($urandom_range(0, 1));
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares handshake state, head word and sideband outputs each cycle
  initial begin
    bit          stalled_prev;
    logic [31:0] held_instr;
    logic [AW-1:0] held_addr;
    stalled_prev = 1'b0;
    held_instr   = '0;
    held_addr    = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("valid_o", 64'(valid_o), 64'(sb.size() != 0));
        checkOutput("ready_o", 64'(ready_o), 64'(sb.size() < 2));
        checkOutput("count_o", 64'(count_o), 64'(model_count));
        checkOutput("err_o", 64'(err_o), 64'(model_err));
        if (stalled_prev && valid_o) begin
          checkOutput("hold_instr", 64'(instr_o), 64'(held_instr));
          checkOutput("hold_addr", 64'(addr_o), 64'(held_addr));
        end
        if (valid_o && sb.size() != 0) begin
          checkOutput("instr_o", 64'(instr_o), 64'(sb[0].instr));
          checkOutput("addr_o", 64'(addr_o), 64'(sb[0].addr));
          if (ready_i) void'(sb.pop_front());
        end
        stalled_prev = valid_o && !ready_i;
        held_instr   = instr_o;
        held_addr    = addr_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    ready_mode    = 2;
    mon_en        = 1'b0;
    rst_i         = 1'b1;
    valid_i       = 1'b0;
    ready_i       = 1'b0;
    op_i          = '0;
    rd_i          = '0;
    rs1_i         = '0;
    rs2_i         = '0;
    imm_i         = '0;
    model_addr    = BASE;
    model_count   = 0;
    model_err     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    checkOutput("reset_instr", 64'(instr_o), 64'd0);
    checkOutput("reset_addr", 64'(addr_o), 64'd0);
    mon_en = 1'b1;

    // Directed words with known encodings
    ready_mode = 0;
    applyStimulus(3, 1, 0, 0, 32'd5, 1'b1, 32'h00500093, 20);
    applyStimulus(0, 3, 1, 2, 32'd0, 1'b1, 32'h002081B3, 20);
    applyStimulus(10, 5, 0, 0, 32'h12345000, 1'b1, 32'h123452B7, 20);
    applyStimulus(8, 0, 1, 2, 32'd4, 1'b1, 32'h00208223, 20);
    applyStimulus(9, 0, 1, 2, -32'sd8, 1'b1, 32'hFE209CE3, 20);
    applyStimulus(11, 1, 0, 0, 32'd16, 1'b1, 32'h010000EF, 20);
    drain(20);

    // Stall: two words fill the FIFO, the third waits until the consumer resumes
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(1, 7, 8, 9, 32'd0, 1'b0, 32'h0, 20);
    applyStimulus(4, 10, 11, 0, 32'h0000_0ABC, 1'b0, 32'h0, 20);
    fork
      applyStimulus(6, 12, 13, 0, 32'd17, 1'b0, 32'h0, 50);
      begin
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain(20);

    // Illegal op sets the sticky flag and leaves the address untouched
    applyStimulus(14, 1, 2, 3, 32'd0, 1'b0, 32'h0, 20);
    applyStimulus(12, 1, 2, 0, 32'h0000_0FFF, 1'b0, 32'h0, 20);
    drain(20);

    // Reset with two words queued discards them and restarts the address
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(2, 1, 2, 3, 32'd0, 1'b0, 32'h0, 20);
    applyStimulus(7, 4, 5, 0, 32'd33, 1'b0, 32'h0, 20);
    doReset();
    ready_mode = 0;
    applyStimulus(3, 2, 2, 0, 32'd1, 1'b0, 32'h0, 20);
    drain(20);

    // Random mix, including illegal codes, against a random consumer
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    $urandom(), 1'b0, 32'h0, 40);
    end
    drain(40);

    // Long legal stream: address wraps many times and the count saturates
    ready_mode = 0;
    for (int n = 0; n < 65545; n++) begin
      applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    $urandom(), 1'b0, 32'h0, 20);
    end
    drain(20);
    checkOutput("count_saturated", 64'(count_o), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder for the supported RV32I subset, the encode-side counterpart of the core's main control decoder. It accepts a mnemonic code plus register and immediate fields over a valid/ready handshake and packs them into 32-bit instruction words. Each word is delivered with an auto-incrementing byte address through a 2-entry output FIFO. It sits between the test/boot program generator and the instruction-memory write port.

## Interface
- ADDR_WIDTH, default 12: byte-address width of `addr_o`.
- BASE_ADDR, default 0: first address emitted after reset; word-aligned, so bits [1:0] are 0.
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- valid_i  in  1  input fields are valid.
- ready_o  out  1  encoder can accept this cycle.
- op_i  in  4  mnemonic code (see Operation).
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  signed immediate (LUI: full 32-bit value, upper 20 bits used).
- valid_o  out  1  FIFO head holds a word.
- ready_i  in  1  consumer takes the head word this cycle.
- instr_o  out  32  encoded instruction at FIFO head.
- addr_o  out  ADDR_WIDTH  byte address of the head word.
- count_o  out  16  number of legal words accepted since reset; saturates at 0xFFFF.
- err_o  out  1  sticky flag; set by any accepted illegal op.

## Operation
- Mnemonic codes, with opcode / funct3 / funct7:
  - 0 ADD 0110011/000/0000000; 1 XOR /100/0; 2 AND /111/0.
  - 3 ADDI 0010011/000; 4 ANDI /111; 5 SLLI /001, funct7 0, shamt=imm[4:0]; 6 SRLI /101, funct7 0, shamt=imm[4:0].
  - 7 LBU 0000011/100 (I-type); 8 SB 0100011/000 (S-type); 9 BNE 1100011/001 (B-type).
  - 10 LUI 0110111 (U-type, imm[31:12]); 11 JAL 1101111 (J-type); 12 JALR 1100111/000 (I-type).
  - 13–15 are illegal.
- Immediates are truncated to the format field widths; no range checking. B/J bit 0 is ignored. Fields not used by a format are ignored (e.g. rs2 for I-type).
- Accept occurs when valid_i && ready_o.
  - Legal op: the encoded word and the current address counter are pushed into the FIFO. The address counter advances by 4 and wraps modulo 2^ADDR_WIDTH. count_o increments.
  - Illegal op: nothing is pushed, the address and count are unchanged, and err_o is set to 1. It stays 1 until reset.
- Pop occurs when valid_o && ready_i; the head entry advances.
- FIFO is 2 entries with separate read/write pointers plus an occupancy counter (0..2).
- ready_o = occupancy < 2. It is registered-state-derived only; there is no combinational path from ready_i.
- Simultaneous push and pop at occupancy 2 is not possible, because ready_o=0. At occupancy 1 both proceed and occupancy stays 1. At occupancy 0 only a push is possible.

## Timing
- Reset values: ready_o=1, valid_o=0, instr_o=0, addr_o=0, count_o=0, err_o=0; address counter=BASE_ADDR; FIFO empty.
- Latency: a word accepted in cycle N appears at instr_o/addr_o with valid_o=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle while ready_i=1 continuously.
- instr_o/addr_o hold stable while valid_o=1 && ready_i=0.
- Reset mid-stream: FIFO contents are discarded, and the counter returns to BASE_ADDR on the next edge. Inputs presented during rst_i are not accepted.
- An illegal op with the FIFO full is not accepted (ready_o=0), so err_o does not set.

## Structure
- Shared package `instr_enc_pkg`:
  - mnemonic enum (4-bit);
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR;
  - funct3 constants.
- Sub-module `instr_pack`: the combinational field-packing function (op, rd, rs1, rs2, imm → word, legal).
- The top level holds the FIFO, pointers, address counter, count and err logic.

## Test plan
- After reset, accept ADDI x1,x0,5 → next cycle valid_o=1, instr_o=0x00500093, addr_o=BASE_ADDR.
- Back-to-back with ready_i=1: ADD x3,x1,x2, LUI x5,0x12345000, SB x2,4(x1) → 0x002081B3, 0x123452B7, 0x00208223 at addresses +0, +4, +8; count_o=3.
- BNE x1,x2,-8 → 0xFE209CE3; JAL x1,16 → 0x010000EF.
- ready_i=0 while pushing 3 words → ready_o falls after 2 accepts and the third is held off. Raising ready_i drains the words in order with stable outputs while stalled.
- op_i=14 accepted → no push, err_o=1 persists, next legal word uses the unchanged address. Also: ADDR_WIDTH=4 and 5 words → addresses 0,4,8,12,0.
- Assert rst_i with 2 words queued → valid_o=0 and addr restarts at BASE_ADDR. Also: count_o saturates at 0xFFFF after 65536+ accepts.
